// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width,
// default watchdog limit and a constant-friendly ceil(log2) helper.
package uart_pkg;

    localparam int BYTE_W             = 8;
    localparam int TIMEOUT_CYCLES_DEF = 512;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE      = 2'd0;
    localparam state_t S_LOAD      = 2'd1;
    localparam state_t S_WAIT_ACT  = 2'd2;
    localparam state_t S_WAIT_DONE = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: while a packet lock is held only the owner
// may be chosen, otherwise the first valid requester at or after rr_ptr wins.
module rr_pick
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   rr_ptr_i,
    input  logic             lock_i,
    input  logic [IDW-1:0]   owner_i,
    output logic             gnt_valid_o,
    output logic [IDW-1:0]   gnt_id_o
);

    always_comb begin
        int idx;
        idx         = 0;
        gnt_valid_o = 1'b0;
        gnt_id_o    = '0;
        if (lock_i) begin
            gnt_valid_o = req_i[owner_i];
            gnt_id_o    = owner_i;
        end else begin
            // Walk offsets from farthest to nearest so the nearest hit is kept.
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_i) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (req_i[idx]) begin
                    gnt_valid_o = 1'b1;
                    gnt_id_o    = IDW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmitter between N_REQ packet streams, arbitrating
// round-robin at packet boundaries, with a sticky watchdog for a stuck transmitter.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int IDW            = clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [BYTE_W*N_REQ-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [BYTE_W-1:0]        tx_din,
    input  logic                     tx_active,
    input  logic                     tx_done,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic                     timeout_err,
    input  logic                     err_clear
);

    localparam int             WDW     = clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [BYTE_W-1:0]  din_q, din_d;
    logic               last_q, last_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               lock_q, lock_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic               err_q, err_d;

    logic               gnt_valid;
    logic [IDW-1:0]     gnt_id;
    logic               accept;
    logic               waiting;
    logic               done_hit;
    logic               wd_fire;

    function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] g);
        if (int'(g) == N_REQ - 1) return '0;
        return g + IDW'(1);
    endfunction

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .lock_i      (lock_q),
        .owner_i     (gid_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // A still-running frame (e.g. across our own reset) holds off any new grant.
    assign accept   = (state_q == S_IDLE) && !tx_active && gnt_valid;
    assign waiting  = (state_q == S_WAIT_ACT) || (state_q == S_WAIT_DONE);
    assign done_hit = (state_q == S_WAIT_DONE) && tx_done;
    assign wd_fire  = waiting && (wd_q == WD_LAST) && !done_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_LOAD;
            S_LOAD:      state_d = S_WAIT_ACT;
            S_WAIT_ACT:  if (wd_fire) state_d = S_IDLE;
                         else if (tx_active) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (done_hit || wd_fire) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_id] = 1'b1;
        tx_start  = (state_q == S_LOAD);
        busy      = (state_q != S_IDLE) || lock_q;
    end

    always_comb begin
        din_d    = din_q;
        last_d   = last_q;
        gid_d    = gid_q;
        lock_d   = lock_q;
        rr_ptr_d = rr_ptr_q;
        wd_d     = wd_q;
        err_d    = err_q;
        if (accept) begin
            din_d  = req_data[int'(gnt_id)*BYTE_W +: BYTE_W];
            last_d = req_last[gnt_id];
            gid_d  = gnt_id;
            lock_d = 1'b1;
            wd_d   = '0;
        end
        if (waiting) wd_d = wd_q + WDW'(1);
        if (done_hit && last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = ptr_after(gid_q);
        end
        // Abandon the packet on a watchdog fire; a same-cycle clear loses.
        if (err_clear) err_d = 1'b0;
        if (wd_fire) begin
            lock_d   = 1'b0;
            rr_ptr_d = ptr_after(gid_q);
            err_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q    <= '0;
            last_q   <= 1'b0;
            gid_q    <= '0;
            rr_ptr_q <= '0;
            lock_q   <= 1'b0;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            din_q    <= din_d;
            last_q   <= last_d;
            gid_q    <= gid_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

    assign tx_din      = din_q;
    assign grant_id    = gid_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: one arbiter driving a behavioural 8N1 transmitter, plus a
// second arbiter with a short watchdog and a transmitter that never responds.
module tb_uart_tx_arbiter;

    localparam int CPB = 39;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        tx_start, busy, timeout_err, err_clear;
    logic [7:0]  tx_din;
    logic [1:0]  grant_id;
    logic        tx_active = 1'b0;
    logic        tx_done   = 1'b0;

    logic        w_rst_n;
    logic [3:0]  w_valid, w_last, w_ready;
    logic [31:0] w_data;
    logic        w_start, w_busy, w_err, w_clr;
    logic [7:0]  w_din;
    logic [1:0]  w_gid;
    logic        w_active, w_done;

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(512)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_din(tx_din), .tx_active(tx_active), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
        .err_clear(err_clear)
    );

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut_wd (
        .clk(clk), .rst_n(w_rst_n), .req_valid(w_valid), .req_data(w_data),
        .req_last(w_last), .req_ready(w_ready), .tx_start(w_start),
        .tx_din(w_din), .tx_active(w_active), .tx_done(w_done),
        .grant_id(w_gid), .busy(w_busy), .timeout_err(w_err),
        .err_clear(w_clr)
    );

    // Behavioural transmitter (no reset): start bit, 8 data LSB first, stop bit.
    logic [9:0] m_frame = 10'h3FF;
    int         m_bit = 0, m_cnt = 0;
    logic       tx_serial;

    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (!tx_active) begin
            if (tx_start) begin
                tx_active <= 1'b1;
                m_frame   <= {1'b1, tx_din, 1'b0};
                m_bit     <= 0;
                m_cnt     <= 0;
            end
        end else if (m_cnt == CPB - 1) begin
            m_cnt <= 0;
            if (m_bit == 9) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
            end else begin
                m_bit <= m_bit + 1;
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign tx_serial = tx_active ? m_frame[m_bit] : 1'b1;

    // Line monitor: decode each frame mid-bit, count start pulses.
    logic [9:0] frames[$];
    int         start_cnt = 0, start_dbl = 0;
    logic       start_prev = 1'b0;

    always @(negedge clk) begin
        if (tx_start) start_cnt++;
        if (tx_start && start_prev) start_dbl++;
        start_prev = tx_start;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                logic [9:0] f;
                f = '0;
                repeat (CPB / 2 + 1) @(negedge clk);
                for (int k = 0; k < 10; k++) begin
                    f[k] = tx_serial;
                    if (k < 9) repeat (CPB) @(negedge clk);
                end
                frames.push_back(f);
            end
        end
    end

    int n_checks = 0, n_errors = 0;
    int fidx = 0, stray = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] fr(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input int idx, input string tag);
        int n;
        n = 0;
        #1;
        while (req_ready[idx] !== 1'b1 && n < 2000) begin
            if (req_ready !== 4'b0) stray++;
            tick();
            #1;
            n++;
        end
        check(tag, req_ready, 32'(4'b0001 << idx));
    endtask

    task automatic wait_frames(input int cnt, input string tag);
        int n;
        n = 0;
        while (frames.size() < cnt && n < 6000) begin
            tick();
            n++;
        end
        check(tag, frames.size(), cnt);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        #1;
        while ((busy || tx_active) && n < 2000) begin
            tick();
            #1;
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b);
        check(tag, frames[fidx], fr(b));
        fidx++;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, s0, bad_rdy, bad_busy;
        rst_n = 1'b0; w_rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; err_clear = 1'b0;
        w_valid = '0; w_last = '0; w_data = '0; w_clr = 1'b0;
        w_active = 1'b0; w_done = 1'b0;
        tick(2);
        #1;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_din", tx_din, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_rr_ptr", dut.rr_ptr_q, 0);
        tick();
        rst_n = 1'b1; w_rst_n = 1'b1;
        tick();

        // Single byte 0xA5 from requester 1.
        req_data[15:8] = 8'hA5; req_last = 4'b0010; req_valid = 4'b0010;
        wait_ready(1, "t1_ready");
        check("t1_no_start_at_T", tx_start, 0);
        tick(); #1;
        check("t1_start_T1", tx_start, 1);
        check("t1_ready_T1", req_ready, 0);
        check("t1_din", tx_din, 8'hA5);
        check("t1_gid", grant_id, 1);
        req_valid = '0;
        tick(); #1;
        check("t1_start_T2", tx_start, 0);
        wait_frames(fidx + 1, "t1_frames");
        check_frame("t1_wire", 8'hA5);
        wait_idle("t1_idle");
        check("t1_rr_ptr", dut.rr_ptr_q, 2);

        // Fairness after a fresh reset: 10,11,12,13 then 10 again.
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick();
        req_data = 32'h13121110; req_last = 4'hF; req_valid = 4'hF;
        s0 = start_cnt; n = 0;
        while (start_cnt < s0 + 5 && n < 3000) begin tick(); n++; end
        req_valid = '0;
        check("t2_starts", start_cnt - s0, 5);
        wait_frames(fidx + 5, "t2_frames");
        check_frame("t2_b0", 8'h10);
        check_frame("t2_b1", 8'h11);
        check_frame("t2_b2", 8'h12);
        check_frame("t2_b3", 8'h13);
        check_frame("t2_b4", 8'h10);
        wait_idle("t2_idle");

        // Packet lock: req2 sends C0..C2 while req0 waits with 0x55 (rr_ptr is 1).
        req_data = 32'h00C00055; req_last = 4'b0001; req_valid = 4'b0101; stray = 0;
        wait_ready(2, "t3_c0");
        tick(); req_data[23:16] = 8'hC1;
        wait_ready(2, "t3_c1");
        tick(); req_data[23:16] = 8'hC2; req_last = 4'b0101;
        wait_ready(2, "t3_c2");
        tick(); req_valid = 4'b0001;
        check("t3_req0_blocked", stray, 0);
        wait_ready(0, "t3_55");
        tick(); req_valid = '0;
        wait_frames(fidx + 4, "t3_frames");
        check_frame("t3_w0", 8'hC0);
        check_frame("t3_w1", 8'hC1);
        check_frame("t3_w2", 8'hC2);
        check_frame("t3_w3", 8'h55);
        wait_idle("t3_idle");

        // Owner stall: req3 holds the lock through a 500-cycle gap, req1 waits.
        req_data = 32'h31000000; req_last = 4'b0000; req_valid = 4'b1000;
        wait_ready(3, "t6_b0");
        tick(); req_data = 32'h32007700; req_last = 4'b0010; req_valid = 4'b1010;
        wait_ready(3, "t6_b1");
        tick(); req_valid = 4'b0010;
        bad_rdy = 0; bad_busy = 0;
        repeat (500) begin
            tick(); #1;
            if (req_ready !== 4'b0) bad_rdy++;
            if (busy !== 1'b1) bad_busy++;
        end
        check("t6_no_grant", bad_rdy, 0);
        check("t6_busy", bad_busy, 0);
        check("t6_owner", grant_id, 3);
        req_data[31:24] = 8'h3C; req_last = 4'b1010; req_valid = 4'b1010;
        wait_ready(3, "t6_resume");
        tick(); req_valid = 4'b0010;
        wait_ready(1, "t6_req1");
        tick(); req_valid = '0;
        wait_frames(fidx + 4, "t6_frames");
        check_frame("t6_w0", 8'h31);
        check_frame("t6_w1", 8'h32);
        check_frame("t6_w2", 8'h3C);
        check_frame("t6_w3", 8'h77);
        wait_idle("t6_idle");

        // Reset during data bit 3 of 0x96; no grant until the frame ends.
        req_data = 32'h00000096; req_last = 4'b0001; req_valid = 4'b0001;
        wait_ready(0, "t5_first");
        tick(); req_valid = '0;
        tick(1 + 4 * CPB + 10);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_tx_still_active", tx_active, 1);
        tick(3);
        rst_n = 1'b1;
        req_data[7:0] = 8'h5A; req_valid = 4'b0001;
        wait_ready(0, "t5_second");
        check("t5_hold_active", tx_active, 0);
        check("t5_first_done", frames.size(), fidx + 1);
        tick(); req_valid = '0;
        wait_frames(fidx + 2, "t5_frames");
        check_frame("t5_w0", 8'h96);
        check_frame("t5_w1", 8'h5A);
        wait_idle("t5_idle");

        // Watchdog with TIMEOUT_CYCLES=16 and a silent transmitter.
        w_data = 32'h0000E1E0; w_last = 4'b0011; w_valid = 4'b0011;
        #1;
        check("t4_first", w_ready, 4'b0001);
        tick(); #1;
        check("t4_start", w_start, 1);
        check("t4_din0", w_din, 8'hE0);
        w_valid = 4'b0010;
        n = 1;
        while (!w_err && n < 100) begin tick(); #1; n++; end
        // Accept edge -> LOAD -> counter 0..15 in WAIT_ACT -> flag: 16+2 samples.
        check("t4_latency", n, 18);
        check("t4_idle", w_busy, 0);
        check("t4_next", w_ready, 4'b0010);
        check("t4_gid_old", w_gid, 0);
        tick(); #1;
        check("t4_start2", w_start, 1);
        check("t4_din1", w_din, 8'hE1);
        check("t4_gid_new", w_gid, 1);
        w_valid = '0; w_clr = 1'b1;
        tick(); w_clr = 1'b0; #1;
        check("t4_cleared", w_err, 0);
        tick(15); #1;
        check("t4_pre_fire", w_err, 0);
        w_clr = 1'b1;
        tick(); w_clr = 1'b0; #1;
        check("t4_fire_wins", w_err, 1);
        tick(3); #1;
        check("t4_sticky", w_err, 1);
        check("t4_idle2", w_busy, 0);

        check("tx_start_width", start_dbl, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
